// File: rtl/conv33_pkg.sv
// Shared types and constants for the 3x3 convolution sequencer slice.
package conv33_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    WIN_REQ,
    FIRE,
    WAIT_V,
    WRITE,
    DONE
  } state_t;

  localparam int unsigned NUM_TAPS      = 9;
  localparam int unsigned WEIGHT_RD_LAT = 1;
  localparam int unsigned MIN_DIM       = 3;

endpackage

// File: rtl/conv33_ctrl_if.sv
// Signal bundle between conv33_ctrl (master) and scheduler/datapath/memories (slave).
interface conv33_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_WIDTH  = 32,
  parameter int DIM_W      = 8,
  parameter int ADDR_W     = 16
);
  logic                  start;
  logic [DIM_W-1:0]      cfg_img_w;
  logic [DIM_W-1:0]      cfg_img_h;
  logic                  busy;
  logic                  done;
  logic                  cfg_err;
  logic                  w_rd_en;
  logic [3:0]            w_rd_addr;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  weight_we;
  logic [3:0]            weight_idx;
  logic [DATA_WIDTH-1:0] weight_wdata;
  logic                  win_req;
  logic [DIM_W-1:0]      win_row;
  logic [DIM_W-1:0]      win_col;
  logic                  win_ready;
  logic                  conv33_en;
  logic                  calc_valid;
  logic [OUT_WIDTH-1:0]  calc_result;
  logic                  out_we;
  logic [ADDR_W-1:0]     out_addr;
  logic [OUT_WIDTH-1:0]  out_data;
  logic                  out_ready;

  modport master (
    input  start, cfg_img_w, cfg_img_h, w_rd_data, win_ready,
           calc_valid, calc_result, out_ready,
    output busy, done, cfg_err, w_rd_en, w_rd_addr, weight_we, weight_idx,
           weight_wdata, win_req, win_row, win_col, conv33_en,
           out_we, out_addr, out_data
  );

  modport slave (
    output start, cfg_img_w, cfg_img_h, w_rd_data, win_ready,
           calc_valid, calc_result, out_ready,
    input  busy, done, cfg_err, w_rd_en, w_rd_addr, weight_we, weight_idx,
           weight_wdata, win_req, win_row, win_col, conv33_en,
           out_we, out_addr, out_data
  );
endinterface

// File: rtl/conv33_win_cnt.sv
// Raster window counters: row/col of the window top-left and linear output address.
module conv33_win_cnt
  import conv33_pkg::*;
#(
  parameter int DIM_W  = 8,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              adv,
  input  logic [DIM_W-1:0]  img_w,
  input  logic [DIM_W-1:0]  img_h,
  output logic [DIM_W-1:0]  row,
  output logic [DIM_W-1:0]  col,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [DIM_W-1:0] col_max;
  logic [DIM_W-1:0] row_max;

  assign col_max = img_w - DIM_W'(MIN_DIM);
  assign row_max = img_h - DIM_W'(MIN_DIM);
  assign last    = (row == row_max) && (col == col_max);

  // addr tracks row*(w-2)+col incrementally, so no multiplier is needed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row  <= '0;
      col  <= '0;
      addr <= '0;
    end else if (clr) begin
      row  <= '0;
      col  <= '0;
      addr <= '0;
    end else if (adv) begin
      addr <= addr + ADDR_W'(1);
      if (col == col_max) begin
        col <= '0;
        row <= row + DIM_W'(1);
      end else begin
        col <= col + DIM_W'(1);
      end
    end
  end

endmodule

// File: rtl/conv33_ctrl.sv
// Layer sequencer: loads kernel weights, walks valid 3x3 windows, fires datapath, writes results.
module conv33_ctrl
  import conv33_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_WIDTH  = 32,
  parameter int DIM_W      = 8,
  parameter int ADDR_W     = 16
) (
  input  logic          clk,
  input  logic          rst,
  conv33_ctrl_if.master bus
);

  localparam logic [3:0] LD_TAPS = 4'(NUM_TAPS);
  localparam logic [3:0] LD_LAT  = 4'(WEIGHT_RD_LAT);
  localparam logic [3:0] LD_LAST = 4'(NUM_TAPS + WEIGHT_RD_LAT - 1);

  state_t            state;
  state_t            state_nxt;
  logic [DIM_W-1:0]  img_w_q;
  logic [DIM_W-1:0]  img_h_q;
  logic              err_q;
  logic [3:0]        ld_cnt;
  logic              dim_bad;
  logic              cnt_clr;
  logic              cnt_adv;
  logic [DIM_W-1:0]  row;
  logic [DIM_W-1:0]  col;
  logic [ADDR_W-1:0] addr;
  logic              last;

  assign dim_bad = (bus.cfg_img_w < DIM_W'(MIN_DIM)) || (bus.cfg_img_h < DIM_W'(MIN_DIM));

  conv33_win_cnt #(
    .DIM_W  (DIM_W),
    .ADDR_W (ADDR_W)
  ) u_win_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .adv   (cnt_adv),
    .img_w (img_w_q),
    .img_h (img_h_q),
    .row   (row),
    .col   (col),
    .addr  (addr),
    .last  (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      img_w_q <= '0;
      img_h_q <= '0;
      err_q   <= 1'b0;
      ld_cnt  <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        img_w_q <= bus.cfg_img_w;
        img_h_q <= bus.cfg_img_h;
        err_q   <= dim_bad;
      end
      ld_cnt <= (state == LOAD_W && state_nxt == LOAD_W) ? ld_cnt + 4'd1 : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = dim_bad ? DONE : LOAD_W;
      LOAD_W:  if (ld_cnt == LD_LAST) state_nxt = WIN_REQ;
      WIN_REQ: if (bus.win_ready) state_nxt = FIRE;
      FIRE:    state_nxt = WAIT_V;
      WAIT_V:  if (bus.calc_valid) state_nxt = WRITE;
      WRITE:   if (bus.out_ready) state_nxt = last ? DONE : WIN_REQ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Data outputs are gated by state so every output is 0 outside its strobe
  always_comb begin
    bus.busy         = (state != IDLE);
    bus.done         = (state == DONE);
    bus.cfg_err      = (state == DONE) && err_q;
    bus.w_rd_en      = 1'b0;
    bus.w_rd_addr    = '0;
    bus.weight_we    = 1'b0;
    bus.weight_idx   = '0;
    bus.weight_wdata = '0;
    bus.win_req      = 1'b0;
    bus.win_row      = '0;
    bus.win_col      = '0;
    bus.conv33_en    = 1'b0;
    bus.out_we       = 1'b0;
    bus.out_addr     = '0;
    bus.out_data     = '0;
    cnt_clr          = 1'b0;
    cnt_adv          = 1'b0;
    unique case (state)
      LOAD_W: begin
        cnt_clr = 1'b1;
        if (ld_cnt < LD_TAPS) begin
          bus.w_rd_en   = 1'b1;
          bus.w_rd_addr = ld_cnt;
        end
        if (ld_cnt >= LD_LAT) begin
          bus.weight_we    = 1'b1;
          bus.weight_idx   = ld_cnt - LD_LAT;
          bus.weight_wdata = DATA_WIDTH'(bus.w_rd_data);
        end
      end
      WIN_REQ: begin
        bus.win_req = 1'b1;
        bus.win_row = row;
        bus.win_col = col;
      end
      FIRE: bus.conv33_en = 1'b1;
      WRITE: begin
        bus.out_we   = bus.out_ready;
        bus.out_addr = addr;
        bus.out_data = OUT_WIDTH'(bus.calc_result);
        cnt_adv      = bus.out_ready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_conv33_ctrl.sv
// Directed bench for conv33_ctrl with a behavioural window/weight/output model.
module tb_conv33_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv33_ctrl_if #(.DATA_WIDTH(8), .OUT_WIDTH(32), .DIM_W(8), .ADDR_W(16)) bus ();

  conv33_ctrl #(.DATA_WIDTH(8), .OUT_WIDTH(32), .DIM_W(8), .ADDR_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int edges = 0;

  // run description, written by the stimulus process only
  int s0 = 0, done_cyc = 0, exp_n = 0, cur_w = 5;
  bit exp_err = 0, run_active = 0, rst_chk = 0;
  int wd_idx = 0, wd_len = 0, st_idx = 0, st_len = 0;
  int pa_idx = -1, pb_idx = -1;
  longint pa_val = 0, pb_val = 0;

  logic [7:0] wreg [9];
  int lr = 0, lc = 0, res_cnt = 0, wr_done = 0, win_cnt = 0;
  int win_wait = 0, stall = 0;
  logic win_ready_d = 1'b0;
  logic out_ready_d = 1'b1;

  always @(posedge clk) edges <= edges + 1;

  function automatic logic [7:0] rom_w(input int k);
    return (k >= 0 && k < 9) ? 8'(k + 1) : 8'd0;
  endfunction

  function automatic longint pix(input int r, input int c);
    return longint'(r * cur_w + c);
  endfunction

  // what the output at grid position (r,c) must be with weights 1..9 and a ramp image
  function automatic logic [31:0] golden(input int r, input int c);
    longint s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += longint'(rom_w(3 * i + j)) * pix(r + i, c + j);
    return 32'(s);
  endfunction

  function automatic logic [31:0] dp_sum(input int r, input int c);
    longint s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += longint'(wreg[3 * i + j]) * pix(r + i, c + j);
    return 32'(s);
  endfunction

  // weight ROM, window fetch and datapath stand-ins
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.calc_valid  <= 1'b0;
      bus.calc_result <= '0;
      bus.w_rd_data   <= '0;
      res_cnt <= 0; wr_done <= 0; win_cnt <= 0; lr <= 0; lc <= 0;
    end else begin
      bus.calc_valid <= 1'b0;
      if (bus.w_rd_en) bus.w_rd_data <= rom_w(int'(bus.w_rd_addr));
      if (bus.weight_we && bus.weight_idx < 4'd9) wreg[bus.weight_idx] <= bus.weight_wdata;
      if (bus.win_req && bus.win_ready) begin
        lr <= int'(bus.win_row); lc <= int'(bus.win_col); win_cnt <= win_cnt + 1;
      end
      if (bus.conv33_en) begin
        bus.calc_valid  <= 1'b1;
        bus.calc_result <= dp_sum(lr, lc);
        res_cnt <= res_cnt + 1;
      end
      if (bus.out_we) wr_done <= wr_done + 1;
      if (!bus.busy) begin res_cnt <= 0; wr_done <= 0; win_cnt <= 0; end
    end
  end

  // handshake driver: optional win_ready delay and out_ready stall
  always @(negedge clk) begin
    if (rst || !bus.busy) begin
      win_ready_d = 1'b0; out_ready_d = 1'b1; win_wait = 0; stall = 0;
    end else begin
      if (bus.win_req) begin
        win_ready_d = (win_cnt + 1 != wd_idx) || (win_wait >= wd_len);
        win_wait++;
      end else begin
        win_ready_d = 1'b0; win_wait = 0;
      end
      if (wr_done + 1 == st_idx && res_cnt >= st_idx && !bus.calc_valid && stall < st_len) begin
        out_ready_d = 1'b0; stall++;
      end else begin
        out_ready_d = 1'b1;
      end
    end
    bus.win_ready = win_ready_d;
    bus.out_ready = out_ready_d;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // single compare process: cycle-indexed expectations from the layer's timing rules
  int cyc, wr_seen, win_seen, en_cnt, gw;
  always @(negedge clk) begin
    #1;
    if (rst_chk) begin
      chk("rst_ctrl", {bus.busy, bus.done, bus.cfg_err, bus.w_rd_en, bus.weight_we,
                       bus.win_req, bus.conv33_en, bus.out_we}, 0);
      chk("rst_addr", {bus.w_rd_addr, bus.weight_idx, bus.win_row, bus.win_col, bus.out_addr}, 0);
      chk("rst_data", {bus.weight_wdata, bus.out_data}, 0);
    end else if (run_active) begin
      cyc = edges - s0 + 1;
      gw  = (cur_w > 2) ? cur_w - 2 : 1;
      if (cyc == 0) begin wr_seen = 0; win_seen = 0; en_cnt = 0; end
      chk("busy", bus.busy, cyc >= 1 && cyc <= done_cyc);
      chk("done", bus.done, cyc == done_cyc);
      chk("cfg_err", bus.cfg_err, cyc == done_cyc && exp_err);
      chk("w_rd_en", bus.w_rd_en, !exp_err && cyc >= 1 && cyc <= 9);
      if (!exp_err && cyc >= 1 && cyc <= 9) chk("w_rd_addr", bus.w_rd_addr, cyc - 1);
      chk("weight_we", bus.weight_we, !exp_err && cyc >= 2 && cyc <= 10);
      if (!exp_err && cyc >= 2 && cyc <= 10) begin
        chk("weight_idx", bus.weight_idx, cyc - 2);
        chk("weight_wdata", bus.weight_wdata, rom_w(cyc - 2));
      end
      if (bus.win_req && bus.win_ready) begin
        chk("win_row", bus.win_row, win_seen / gw);
        chk("win_col", bus.win_col, win_seen % gw);
        win_seen++;
      end
      if (bus.conv33_en) en_cnt++;
      if (bus.out_we) begin
        chk("out_addr", bus.out_addr, wr_seen);
        chk("out_data", bus.out_data, golden(wr_seen / gw, wr_seen % gw));
        if (wr_seen == pa_idx) chk("pin_a", bus.out_data, pa_val);
        if (wr_seen == pb_idx) chk("pin_b", bus.out_data, pb_val);
        wr_seen++;
      end
      if (cyc == done_cyc + 2) begin
        chk("n_writes", wr_seen, exp_n);
        chk("n_fire", en_cnt, exp_n);
        chk("n_windows", win_seen, exp_n);
      end
    end
  end

  task automatic start_layer(input int w, input int h, input int extra,
                             input int wdi, input int wdl, input int sti, input int stl,
                             input int pai, input longint pav, input int pbi, input longint pbv);
    cur_w   = w;
    exp_err = (w < 3 || h < 3);
    exp_n   = exp_err ? 0 : (w - 2) * (h - 2);
    done_cyc = exp_err ? 1 : 11 + 4 * exp_n + extra;
    wd_idx = wdi; wd_len = wdl; st_idx = sti; st_len = stl;
    pa_idx = pai; pa_val = pav; pb_idx = pbi; pb_val = pbv;
    s0 = edges + 1;
    run_active = 1;
    bus.start = 1'b1;
    bus.cfg_img_w = 8'(w);
    bus.cfg_img_h = 8'(h);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    while (edges - s0 + 1 < c) @(negedge clk);
  endtask

  task automatic wait_layer();
    wait_cyc(done_cyc + 3);
    run_active = 0;
  endtask

  task automatic stray_start();
    bus.start = 1'b1; bus.cfg_img_w = 8'd2; bus.cfg_img_h = 8'd2;
    @(negedge clk);
    bus.start = 1'b0; bus.cfg_img_w = 8'd5; bus.cfg_img_h = 8'd5;
  endtask

  initial begin
    bus.start = 1'b0; bus.cfg_img_w = '0; bus.cfg_img_h = '0;
    rst_chk = 1; rst = 1'b1;
    repeat (4) @(negedge clk);
    rst_chk = 0; rst = 1'b0;
    @(negedge clk);

    // 5x5: outputs 45*(5r+c)+366
    start_layer(5, 5, 0, 0, 0, 0, 0, 0, 366, 8, 906);
    wait_layer();

    // 3x3: single window
    start_layer(3, 3, 0, 0, 0, 0, 0, 0, 240, -1, 0);
    wait_layer();

    // bad width
    start_layer(2, 5, 0, 0, 0, 0, 0, -1, 0, -1, 0);
    wait_layer();

    // 4x4: 2nd write stalled 3 cycles, 3rd window delayed 2 cycles
    start_layer(4, 4, 5, 3, 2, 2, 3, 1, 348, 3, 528);
    wait_layer();

    // abort in the WRITE of the 4th output, then full rerun
    start_layer(5, 5, 0, 0, 0, 0, 0, 0, 366, 8, 906);
    wait_cyc(26);
    #3;
    run_active = 0; rst_chk = 1; rst = 1'b1;
    repeat (4) @(negedge clk);
    rst_chk = 0; rst = 1'b0;
    @(negedge clk);
    start_layer(5, 5, 0, 0, 0, 0, 0, 0, 366, 8, 906);
    wait_layer();

    // stray starts during LOAD_W and WIN_REQ
    start_layer(5, 5, 0, 0, 0, 0, 0, 0, 366, 8, 906);
    wait_cyc(3);
    stray_start();
    wait_cyc(11);
    stray_start();
    wait_layer();

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
